fb_scanout: RTL and testbench

- Double-buffered framebuffer that terminates the GPU pixel-write interface (fb_x, fb_y, fb_color, fb_write).
- Streams the front buffer in raster order to the display path over a valid/ready pixel stream.
- The GPU always draws into the back buffer.
- Buffers swap on request, and only at a frame boundary, so scanout never shows a half-drawn frame.

---
 rtl/fb_scanout_pkg.sv | 28 ++
 rtl/fb_scanout_if.sv | 43 ++++
 rtl/fb_bank.sv | 31 +++
 rtl/fb_scanout.sv | 145 ++++++++++++++
 tb/tb_fb_scanout.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_scanout_pkg.sv
// ---------------------------------------------------------------------------
// fb_scanout_pkg : pixel types and framebuffer geometry shared with GPU/display
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fb_scanout_pkg;

  typedef logic [15:0] pixel_t;

  localparam int TRANSPARENT_BIT = 0;
  localparam int FB_WIDTH_DEF    = 400;
  localparam int FB_HEIGHT_DEF   = 240;

  typedef struct packed {
    pixel_t data;
    logic   sof;
    logic   eol;
  } px_beat_t;

  // One spare bit so out-of-range coordinates are representable and can be rejected.
  function automatic int coord_bits(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_scanout_if.sv
// ---------------------------------------------------------------------------
// fb_scanout_if : GPU write port, swap control and display pixel stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fb_scanout_if
  import fb_scanout_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF
) ();

  localparam int XW = coord_bits(FB_WIDTH);
  localparam int YW = coord_bits(FB_HEIGHT);

  logic [XW-1:0] fb_x;
  logic [YW-1:0] fb_y;
  pixel_t        fb_color;
  logic          fb_write;
  logic          swap_req;
  logic          swap_pending;
  logic          front_sel;
  logic          scan_enable;
  logic          px_valid;
  logic          px_ready;
  pixel_t        px_data;
  logic          px_sof;
  logic          px_eol;

  modport master (
    output fb_x, fb_y, fb_color, fb_write, swap_req, scan_enable, px_ready,
    input  swap_pending, front_sel, px_valid, px_data, px_sof, px_eol
  );

  modport slave (
    input  fb_x, fb_y, fb_color, fb_write, swap_req, scan_enable, px_ready,
    output swap_pending, front_sel, px_valid, px_data, px_sof, px_eol
  );

endinterface

`default_nettype wire

// File: rtl/fb_bank.sv
// ---------------------------------------------------------------------------
// fb_bank : simple dual-port frame RAM, one write port, registered read port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fb_bank
  import fb_scanout_pkg::*;
#(
  parameter int DEPTH = FB_WIDTH_DEF * FB_HEIGHT_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  pixel_t        wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output pixel_t        rdata_o
);

  pixel_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

`default_nettype wire

// File: rtl/fb_scanout.sv
// ---------------------------------------------------------------------------
// fb_scanout : double-buffered framebuffer with raster scanout and frame-aligned swap
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
  input logic         clk,
  input logic         rst_n,
  fb_scanout_if.slave bus
);

  localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int XW    = coord_bits(FB_WIDTH);
  localparam int YW    = coord_bits(FB_HEIGHT);

  logic [XW-1:0] sx_q, sx_d;
  logic [YW-1:0] sy_q, sy_d;
  logic          swreq_q;
  logic          swap_pending_q, swap_pending_d;
  logic          front_sel_q, front_sel_d;
  logic          rd_inflight_q, rd_bank_q, rd_sof_q, rd_eol_q;
  px_beat_t      fifo_q [2];
  logic          wptr_q, rptr_q;
  logic [1:0]    cnt_q;

  logic          wr_en, last_x, last_y, pop, issue, swap_do;
  logic [2:0]    occ;
  logic [AW-1:0] waddr, raddr;
  pixel_t        bank_rdata [2];
  pixel_t        rd_pixel;

  assign wr_en = bus.fb_write && (bus.fb_x < XW'(FB_WIDTH)) && (bus.fb_y < YW'(FB_HEIGHT));
  assign waddr = AW'(bus.fb_y) * AW'(FB_WIDTH) + AW'(bus.fb_x);
  assign raddr = AW'(sy_q) * AW'(FB_WIDTH) + AW'(sx_q);

  assign last_x = (sx_q == XW'(FB_WIDTH - 1));
  assign last_y = (sy_q == YW'(FB_HEIGHT - 1));
  assign pop    = (cnt_q != 2'd0) && bus.px_ready;
  // Occupancy after this cycle, counting the read whose data lands next edge.
  assign occ    = 3'(cnt_q) + 3'(rd_inflight_q) - 3'(pop);
  assign issue  = bus.scan_enable && (occ < 3'd2);

  assign swap_do = swap_pending_q && (!bus.scan_enable || (issue && last_x && last_y));

  always_comb begin
    front_sel_d    = front_sel_q ^ swap_do;
    swap_pending_d = swap_pending_q;
    if (swap_do) begin
      swap_pending_d = 1'b0;
    end else if (bus.swap_req && !swreq_q) begin
      swap_pending_d = 1'b1;
    end
  end

  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (!bus.scan_enable) begin
      sx_d = '0;
      sy_d = '0;
    end else if (issue) begin
      if (last_x) begin
        sx_d = '0;
        sy_d = last_y ? '0 : sy_q + YW'(1);
      end else begin
        sx_d = sx_q + XW'(1);
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .clk     (clk),
      .we_i    (wr_en && (front_sel_q != 1'(b))),
      .waddr_i (waddr),
      .wdata_i (bus.fb_color),
      .re_i    (issue),
      .raddr_i (raddr),
      .rdata_o (bank_rdata[b])
    );
  end

  assign rd_pixel = bank_rdata[rd_bank_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q           <= '0;
      sy_q           <= '0;
      swreq_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      front_sel_q    <= 1'b0;
      rd_inflight_q  <= 1'b0;
      rd_bank_q      <= 1'b0;
      rd_sof_q       <= 1'b0;
      rd_eol_q       <= 1'b0;
      wptr_q         <= 1'b0;
      rptr_q         <= 1'b0;
      cnt_q          <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      swreq_q        <= bus.swap_req;
      swap_pending_q <= swap_pending_d;
      front_sel_q    <= front_sel_d;
      sx_q           <= sx_d;
      sy_q           <= sy_d;
      rd_bank_q      <= front_sel_q;
      rd_sof_q       <= (sx_q == '0) && (sy_q == '0);
      rd_eol_q       <= last_x;
      if (!bus.scan_enable) begin
        rd_inflight_q <= 1'b0;
        wptr_q        <= 1'b0;
        rptr_q        <= 1'b0;
        cnt_q         <= 2'd0;
      end else begin
        rd_inflight_q <= issue;
        if (rd_inflight_q) begin
          fifo_q[wptr_q] <= '{data: rd_pixel, sof: rd_sof_q, eol: rd_eol_q};
          wptr_q         <= ~wptr_q;
        end
        if (pop) rptr_q <= ~rptr_q;
        cnt_q <= cnt_q + 2'(rd_inflight_q) - 2'(pop);
      end
    end
  end

  assign bus.px_valid     = (cnt_q != 2'd0);
  assign bus.px_data      = fifo_q[rptr_q].data;
  assign bus.px_sof       = bus.px_valid && fifo_q[rptr_q].sof;
  assign bus.px_eol       = bus.px_valid && fifo_q[rptr_q].eol;
  assign bus.swap_pending = swap_pending_q;
  assign bus.front_sel    = front_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_scanout.sv
// ---------------------------------------------------------------------------
// tb_fb_scanout : directed bench for fb_scanout on a reduced 8x4 frame
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fb_scanout;
  import fb_scanout_pkg::*;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_scanout_if #(.FB_WIDTH(W), .FB_HEIGHT(H)) bus ();

  fb_scanout #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mbank [2][N];
  logic [15:0] cap [N];
  bit   mfront = 1'b0;
  bit   m_pend = 1'b0;
  bit   mon_en = 1'b0;
  int   m_idx = 0;
  int   m_cnt = 0;
  int   m_frames = 0;

  typedef struct {
    logic [3:0]  x;
    logic [2:0]  y;
    logic [15:0] color;
    int          exp_addr;
    logic [15:0] exp_data;
  } wvec_t;

  wvec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_px_valid"}, 32'(bus.px_valid), 32'd0);
    chk({tag, "_px_sof"}, 32'(bus.px_sof), 32'd0);
    chk({tag, "_px_eol"}, 32'(bus.px_eol), 32'd0);
    chk({tag, "_px_data"}, 32'(bus.px_data), 32'd0);
    chk({tag, "_swap_pending"}, 32'(bus.swap_pending), 32'd0);
    chk({tag, "_front_sel"}, 32'(bus.front_sel), 32'd0);
  endtask

  // Stream scoreboard: raster order, sof/eol flags, and hold-stable under backpressure.
  logic        hold_v = 1'b0;
  logic [17:0] hold_b = '0;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (hold_v && bus.px_valid) begin
        checks++;
        if ({bus.px_data, bus.px_sof, bus.px_eol} !== hold_b) begin
          errors++;
          $display("FAIL stable: got %h expected %h", {bus.px_data, bus.px_sof, bus.px_eol}, hold_b);
        end
      end
      hold_v = bus.px_valid && !bus.px_ready;
      hold_b = {bus.px_data, bus.px_sof, bus.px_eol};
      if (bus.px_valid && bus.px_ready) begin
        checks++;
        if (bus.px_data !== mbank[mfront][m_idx] || bus.px_sof !== (m_idx == 0) ||
            bus.px_eol !== ((m_idx % W) == W - 1)) begin
          errors++;
          $display("FAIL pixel idx=%0d: got data=%h sof=%b eol=%b expected data=%h sof=%b eol=%b",
                   m_idx, bus.px_data, bus.px_sof, bus.px_eol, mbank[mfront][m_idx],
                   (m_idx == 0), ((m_idx % W) == W - 1));
        end
        cap[m_idx] = bus.px_data;
        m_idx++;
        m_cnt++;
        if (m_idx == N) begin
          m_idx = 0;
          m_frames++;
          if (m_pend) begin
            mfront = ~mfront;
            m_pend = 1'b0;
          end
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic wait_idx(input int target, input string name);
    int n = 0;
    while (m_idx != target && n < 500) begin
      tick();
      n++;
    end
    if (m_idx != target) chk({name, "_timeout"}, 32'(m_idx), 32'(target));
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (m_frames < target && n < 500) begin
      tick();
      n++;
    end
    if (m_frames < target) chk({name, "_timeout"}, 32'(m_frames), 32'(target));
  endtask

  initial begin
    int c0, start_f, t1;
    bit did1, chkd;

    vt[0] = '{x: 4'd0,  y: 3'd0, color: 16'h1235, exp_addr: 0,  exp_data: 16'h1235};
    vt[1] = '{x: 4'd7,  y: 3'd3, color: 16'hFFFF, exp_addr: 31, exp_data: 16'hFFFF};
    vt[2] = '{x: 4'd8,  y: 3'd0, color: 16'hDEAD, exp_addr: 8,  exp_data: 16'h1008};
    vt[3] = '{x: 4'd0,  y: 3'd4, color: 16'hBEEF, exp_addr: 0,  exp_data: 16'h1235};
    vt[4] = '{x: 4'd15, y: 3'd3, color: 16'hCAFE, exp_addr: 7,  exp_data: 16'h1007};
    vt[5] = '{x: 4'd3,  y: 3'd1, color: 16'h0A0B, exp_addr: 11, exp_data: 16'h0A0B};
    vt[6] = '{x: 4'd2,  y: 3'd7, color: 16'h7777, exp_addr: 26, exp_data: 16'h101A};

    bus.fb_x = '0; bus.fb_y = '0; bus.fb_color = '0; bus.fb_write = 1'b0;
    bus.swap_req = 1'b0; bus.scan_enable = 1'b0; bus.px_ready = 1'b0;

    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Back bank is 1 while front_sel=0.
    for (int i = 0; i < N; i++) begin
      bus.fb_x = 4'(i % W); bus.fb_y = 3'(i / W);
      bus.fb_color = 16'h1000 + 16'(i); bus.fb_write = 1'b1;
      mbank[1][i] = 16'h1000 + 16'(i);
      tick();
    end
    for (int k = 0; k < 7; k++) begin
      bus.fb_x = vt[k].x; bus.fb_y = vt[k].y; bus.fb_color = vt[k].color; bus.fb_write = 1'b1;
      if (vt[k].x < W && vt[k].y < H) mbank[1][int'(vt[k].y) * W + int'(vt[k].x)] = vt[k].color;
      tick();
    end
    bus.fb_write = 1'b0;

    bus.swap_req = 1'b1;
    tick();
    chk("idle_swap_pending", 32'(bus.swap_pending), 32'd1);
    chk("idle_swap_front_before", 32'(bus.front_sel), 32'd0);
    bus.swap_req = 1'b0;
    tick();
    chk("idle_swap_front_after", 32'(bus.front_sel), 32'd1);
    chk("idle_swap_pending_clear", 32'(bus.swap_pending), 32'd0);
    mfront = 1'b1;

    for (int i = 0; i < N; i++) begin
      bus.fb_x = 4'(i % W); bus.fb_y = 3'(i / W);
      bus.fb_color = 16'h2000 + 16'(i); bus.fb_write = 1'b1;
      mbank[0][i] = 16'h2000 + 16'(i);
      tick();
    end
    bus.fb_write = 1'b0;

    m_idx = 0;
    mon_en = 1'b1;
    bus.scan_enable = 1'b1;
    bus.px_ready = 1'b1;
    tick();
    chk("latency_c1_valid", 32'(bus.px_valid), 32'd0);
    tick();
    chk("latency_c2_valid", 32'(bus.px_valid), 32'd1);
    chk("first_px_data", 32'(bus.px_data), 32'h1235);
    chk("first_px_sof", 32'(bus.px_sof), 32'd1);
    wait_frames(1, "frame1");
    for (int k = 0; k < 7; k++) chk($sformatf("readback_%0d", k), 32'(cap[vt[k].exp_addr]), 32'(vt[k].exp_data));

    c0 = m_cnt;
    repeat (20) tick();
    chk("throughput", 32'(m_cnt - c0), 32'd20);

    // 30% ready over two frames, swap requested mid-frame plus a second edge while pending.
    start_f = m_frames + 1;
    did1 = 1'b0; chkd = 1'b0; t1 = 0;
    for (int n = 0; n < 3000 && m_frames < start_f + 2; n++) begin
      bus.px_ready = ($urandom_range(0, 9) < 3);
      bus.swap_req = 1'b0;
      if (m_frames == start_f && m_idx >= 5 && !did1) begin
        bus.swap_req = 1'b1; m_pend = 1'b1; did1 = 1'b1; t1 = n;
      end else if (did1 && n == t1 + 4) begin
        bus.swap_req = 1'b1;
        chk("pending_at_second_edge", 32'(bus.swap_pending), 32'd1);
      end
      if (did1 && !chkd && m_frames == start_f && m_idx == 20) begin
        chk("pending_mid_frame", 32'(bus.swap_pending), 32'd1);
        chkd = 1'b1;
      end
      tick();
    end
    bus.swap_req = 1'b0;
    bus.px_ready = 1'b1;
    chk("random_frames_done", 32'(m_frames), 32'(start_f + 2));
    chk("swap_events_seen", {30'd0, did1, chkd}, 32'd3);
    chk("midframe_front_sel", 32'(bus.front_sel), 32'd0);
    chk("midframe_pending_clear", 32'(bus.swap_pending), 32'd0);

    wait_idx(12, "drop_wait");
    bus.scan_enable = 1'b0;
    tick();
    chk("drop_valid", 32'(bus.px_valid), 32'd0);
    m_idx = 0;
    tick();

    // Swap executes one cycle after the edge while halted; the write in that cycle hits the old back bank.
    bus.swap_req = 1'b1;
    tick();
    chk("swapcyc_pending", 32'(bus.swap_pending), 32'd1);
    bus.swap_req = 1'b0;
    bus.fb_x = 4'd3; bus.fb_y = 3'd2; bus.fb_color = 16'h5A5A; bus.fb_write = 1'b1;
    tick();
    bus.fb_write = 1'b0;
    chk("swapcyc_front_sel", 32'(bus.front_sel), 32'd1);
    mbank[1][2 * W + 3] = 16'h5A5A;
    mfront = 1'b1;

    c0 = m_frames;
    bus.scan_enable = 1'b1;
    tick();
    tick();
    chk("restart_valid", 32'(bus.px_valid), 32'd1);
    chk("restart_sof", 32'(bus.px_sof), 32'd1);
    chk("restart_data", 32'(bus.px_data), 32'h1235);
    wait_frames(c0 + 1, "swapcyc_frame");
    chk("swapcyc_write_visible", 32'(cap[2 * W + 3]), 32'h5A5A);

    wait_idx(10, "reset_wait");
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    chk("pre_reset_pending", 32'(bus.swap_pending), 32'd1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
